// File: rtl/up_down_count_monitor_if.sv
// Count-bus observation interface between an up/down counter and its monitor.
// master = counter side (drives count bus), slave = monitor (drives status).
interface up_down_count_monitor_if #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
);
  logic                 sample_en;
  logic [WIDTH-1:0]     count_in;
  logic                 dir_up;
  logic                 moving;
  logic                 wrap_pulse;
  logic                 rev_pulse;
  logic                 step_err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output sample_en, count_in,
    input  dir_up, moving, wrap_pulse, rev_pulse, step_err, err_cnt
  );

  modport slave (
    input  sample_en, count_in,
    output dir_up, moving, wrap_pulse, rev_pulse, step_err, err_cnt
  );
endinterface

// File: rtl/up_down_count_monitor.sv
// Recovers direction, wrap, reversal and illegal-step events from a sampled counter bus; outputs registered, 1 cycle after sample.
// Optional UDC_MON_STRICT_EN: a hold while moving is an illegal step.
module up_down_count_monitor #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  up_down_count_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_HOLD = 2'd1,
    S_UP   = 2'd2,
    S_DOWN = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_e               state_q;
  logic [WIDTH-1:0]     prev_q;
  logic                 dir_up_q;
  logic                 moving_q;
  logic                 wrap_q;
  logic                 rev_q;
  logic                 err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_d;

  logic [WIDTH-1:0] delta;
  logic             step_up;
  logic             step_dn;
  logic             step_hold;
  logic             step_bad;
  logic             hold_bad;

  always_comb begin
    delta     = mon.count_in - prev_q;
    step_up   = (delta == WIDTH'(1));
    step_dn   = (delta == CNT_MAX);
    step_hold = (delta == '0);
`ifdef UDC_MON_STRICT_EN
    hold_bad  = step_hold && ((state_q == S_UP) || (state_q == S_DOWN));
`else
    hold_bad  = 1'b0;
`endif
    step_bad  = !(step_up || step_dn || step_hold) || hold_bad;
    err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_INIT;
      prev_q    <= '0;
      dir_up_q  <= 1'b1;
      moving_q  <= 1'b0;
      wrap_q    <= 1'b0;
      rev_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      wrap_q <= 1'b0;
      rev_q  <= 1'b0;
      err_q  <= 1'b0;
      if (mon.sample_en) begin
        // prev always follows the bus, so an illegal jump resyncs tracking
        prev_q <= mon.count_in;
        if (state_q == S_INIT) begin
          state_q  <= S_HOLD;
          moving_q <= 1'b0;
        end else if (step_bad) begin
          state_q   <= S_HOLD;
          moving_q  <= 1'b0;
          err_q     <= 1'b1;
          err_cnt_q <= err_cnt_d;
        end else if (step_up) begin
          state_q  <= S_UP;
          moving_q <= 1'b1;
          dir_up_q <= 1'b1;
          rev_q    <= (state_q == S_DOWN);
          wrap_q   <= (prev_q == CNT_MAX);
        end else if (step_dn) begin
          state_q  <= S_DOWN;
          moving_q <= 1'b1;
          dir_up_q <= 1'b0;
          rev_q    <= (state_q == S_UP);
          wrap_q   <= (prev_q == '0);
        end else begin
          state_q  <= S_HOLD;
          moving_q <= 1'b0;
        end
      end
    end
  end

  assign mon.dir_up     = dir_up_q;
  assign mon.moving     = moving_q;
  assign mon.wrap_pulse = wrap_q;
  assign mon.rev_pulse  = rev_q;
  assign mon.step_err   = err_q;
  assign mon.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_up_down_count_monitor.sv
// Bench for up_down_count_monitor: directed scenarios plus randomized traffic against a step-rule model.
module tb_up_down_count_monitor;

`ifdef UDC_MON_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  up_down_count_monitor_if #(.WIDTH(4), .ERR_CNT_W(8)) mif ();
  up_down_count_monitor #(.WIDTH(4), .ERR_CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (mif)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: last value seen, and motion: 0 none, 1 rising, -1 falling
  bit m_has;
  int m_prev;
  int m_motion;
  bit e_dir, e_mov, e_wrap, e_rev, e_err;
  int e_cnt;

  function automatic logic [12:0] obs_vec();
    return {mif.dir_up, mif.moving, mif.wrap_pulse, mif.rev_pulse, mif.step_err, mif.err_cnt};
  endfunction

  function automatic logic [12:0] exp_vec();
    return {e_dir, e_mov, e_wrap, e_rev, e_err, 8'(e_cnt)};
  endfunction

  task automatic cyc(input bit r, input bit en, input int v);
    int d;
    @(negedge clk);
    reset         = r;
    mif.sample_en = en;
    mif.count_in  = v[3:0];
    @(posedge clk);
    e_wrap = 0; e_rev = 0; e_err = 0;
    if (r) begin
      m_has = 0; m_prev = 0; m_motion = 0;
      e_dir = 1; e_mov = 0; e_cnt = 0;
    end else if (en) begin
      if (!m_has) begin
        m_has = 1; m_motion = 0;
      end else begin
        d = (v - m_prev + 16) % 16;
        if (d == 1) begin
          e_rev = (m_motion == -1); e_wrap = (m_prev == 15);
          m_motion = 1; e_dir = 1;
        end else if (d == 15) begin
          e_rev = (m_motion == 1); e_wrap = (m_prev == 0);
          m_motion = -1; e_dir = 0;
        end else if (d == 0 && !(STRICT && m_motion != 0)) begin
          m_motion = 0;
        end else begin
          m_motion = 0; e_err = 1;
          if (e_cnt < 255) e_cnt = e_cnt + 1;
        end
      end
      m_prev = v;
      e_mov = (m_motion != 0);
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 9);
      total++;
      if (obs_vec() !== 13'b1_0_0_0_0_00000000) begin
        bad++;
        $display("FAIL reset_state cyc%0d: got %b want %b", i, obs_vec(), 13'b1_0_0_0_0_00000000);
      end
    end
  endtask

  task automatic test_count_up_wrap();
    int wraps, wrap_at;
    wraps = 0; wrap_at = -1;
    cyc(1, 0, 0);
    for (int i = 0; i <= 16; i++) begin
      cyc(0, 1, i % 16);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL up_seq step%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
      if (mif.wrap_pulse) begin wraps++; wrap_at = i; end
    end
    total++;
    if (wraps !== 1 || wrap_at !== 16) begin
      bad++;
      $display("FAIL up_wrap_once: got count=%0d at=%0d want count=1 at=16", wraps, wrap_at);
    end
    total++;
    if ({mif.moving, mif.dir_up} !== 2'b11) begin
      bad++;
      $display("FAIL up_moving_dir: got %b want 11", {mif.moving, mif.dir_up});
    end
  endtask

  task automatic test_reversal();
    int seq[5] = '{5, 6, 7, 6, 5};
    int revs, errs;
    revs = 0; errs = 0;
    cyc(1, 0, 0);
    foreach (seq[i]) begin
      cyc(0, 1, seq[i]);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL rev_seq step%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
      revs += int'(mif.rev_pulse);
      errs += int'(mif.step_err);
    end
    total++;
    if (revs !== 1 || errs !== 0 || mif.dir_up !== 1'b0) begin
      bad++;
      $display("FAIL rev_once: got rev=%0d err=%0d dir=%b want rev=1 err=0 dir=0", revs, errs, mif.dir_up);
    end
  endtask

  task automatic test_illegal_step();
    cyc(1, 0, 0);
    cyc(0, 1, 3);
    cyc(0, 1, 4);
    cyc(0, 1, 9);
    total++;
    if ({mif.step_err, mif.moving, mif.err_cnt} !== {1'b1, 1'b0, 8'd1}) begin
      bad++;
      $display("FAIL jump_err: got err=%b mov=%b cnt=%0d want err=1 mov=0 cnt=1", mif.step_err, mif.moving, mif.err_cnt);
    end
    cyc(0, 1, 10);
    total++;
    if ({mif.step_err, mif.moving, mif.dir_up, mif.err_cnt} !== {1'b0, 1'b1, 1'b1, 8'd1}) begin
      bad++;
      $display("FAIL resync_up: got err=%b mov=%b dir=%b cnt=%0d want 0 1 1 1", mif.step_err, mif.moving, mif.dir_up, mif.err_cnt);
    end
  endtask

  task automatic test_err_saturate();
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    for (int i = 0; i < 256; i++) cyc(0, 1, (i % 2 == 0) ? 8 : 0);
    total++;
    if (mif.err_cnt !== 8'd255) begin
      bad++;
      $display("FAIL err_sat_256: got %0d want 255", mif.err_cnt);
    end
    cyc(0, 1, 8);
    total++;
    if ({mif.step_err, mif.err_cnt} !== {1'b1, 8'd255}) begin
      bad++;
      $display("FAIL err_sat_hold: got err=%b cnt=%0d want err=1 cnt=255", mif.step_err, mif.err_cnt);
    end
  endtask

  task automatic test_hold_and_midreset();
    cyc(1, 0, 0);
    cyc(0, 1, 7);
    cyc(0, 1, 8);
    cyc(0, 1, 8);
    total++;
    if ({mif.step_err, mif.err_cnt} !== {STRICT, 8'(STRICT)}) begin
      bad++;
      $display("FAIL hold_moving: got err=%b cnt=%0d want err=%b cnt=%0d", mif.step_err, mif.err_cnt, STRICT, STRICT);
    end
    cyc(0, 1, 9);
    cyc(1, 1, 9);
    cyc(0, 1, 15);
    total++;
    if (obs_vec() !== 13'b1_0_0_0_0_00000000) begin
      bad++;
      $display("FAIL midreset_first: got %b want %b", obs_vec(), 13'b1_0_0_0_0_00000000);
    end
    cyc(0, 1, 0);
    total++;
    if (obs_vec() !== 13'b1_1_1_0_0_00000000) begin
      bad++;
      $display("FAIL midreset_wrap: got %b want %b", obs_vec(), 13'b1_1_1_0_0_00000000);
    end
  endtask

  task automatic test_random();
    int v, pick;
    bit r, en;
    cyc(1, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      r    = ($urandom_range(0, 59) == 0);
      en   = ($urandom_range(0, 5) != 0);
      pick = $urandom_range(0, 9);
      if (pick < 4)       v = (m_prev + 1) % 16;
      else if (pick < 7)  v = (m_prev + 15) % 16;
      else if (pick < 8)  v = m_prev;
      else                v = $urandom_range(0, 15);
      cyc(r, en, v);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL random cyc%0d rst=%b en=%b v=%0d: got %b want %b", i, r, en, v, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    mif.sample_en = 1'b0;
    mif.count_in  = '0;
    test_reset();
    test_count_up_wrap();
    test_reversal();
    test_illegal_step();
    test_err_saturate();
    test_hold_and_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
